// File: rtl/rib_rr_xbar_if.sv
// Master/slave bundle of the RIB crossbar; the crossbar binds the master modport
// (it masters the slave side), the attached agents bind the slave modport.
interface rib_rr_xbar_if #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [NUM_M-1:0]    m_req_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0] m_data_i;
  logic [NUM_M-1:0]    m_gnt_o;
  logic [NUM_M-1:0]    m_rvalid_o;
  logic [NUM_M*DW-1:0] m_data_o;
  logic [NUM_M-1:0]    m_err_o;
  logic [NUM_S-1:0]    s_req_o;
  logic [NUM_S-1:0]    s_we_o;
  logic [NUM_S*AW-1:0] s_addr_o;
  logic [NUM_S*DW-1:0] s_data_o;
  logic [NUM_S*DW-1:0] s_data_i;
  logic [NUM_S-1:0]    s_ack_i;

  modport master (
    input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    output m_gnt_o, m_rvalid_o, m_data_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_data_o
  );

  modport slave (
    output m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    input  m_gnt_o, m_rvalid_o, m_data_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_data_o
  );
endinterface

// File: rtl/rib_rr_xbar.sv
// Round-robin NUM_M x NUM_S shared-path bus (fixed priority with RIB_FIXED_PRIO_EN); gnt at N+1,
// rvalid at N+2 plus slave wait states; masters hold their request until gnt, slaves stall via s_ack_i.
module rib_rr_xbar #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 8,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT = 255,
  parameter logic [7:0] HOLD_MASK = 8'b0000_1101
) (
  input  logic clk,
  input  logic rst,
  rib_rr_xbar_if.master bus,
  output logic hold_flag_o
);
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam logic [NUM_M-1:0] HMASK = HOLD_MASK[NUM_M-1:0];

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       owner_q, owner_d;
  logic [AW-SEL_BITS-1:0] addr_q, addr_d;
  logic                we_q, we_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [SW-1:0]       slv_q, slv_d;
  logic                dec_err_q, dec_err_d;
  logic                err_q, err_d;
  logic                gnt_q, gnt_d;
  logic [15:0]         cnt_q, cnt_d;
`ifndef RIB_FIXED_PRIO_EN
  logic [MW-1:0]       last_q, last_d;
`endif

  logic [MW-1:0]       win, cand;
  logic                found;
  logic [AW-1:0]       cand_addr;
  logic [SEL_BITS-1:0] cand_sel;

  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
`ifdef RIB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_M; i++) begin
      cand = MW'(i);
      if (bus.m_req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
`else
    // Walk from farthest to nearest so the requester closest after last wins.
    for (int i = NUM_M; i >= 1; i--) begin
      cand = MW'((int'(last_q) + i) % NUM_M);
      if (bus.m_req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
`endif
  end

  assign cand_addr = bus.m_addr_i[int'(win)*AW +: AW];
  assign cand_sel  = cand_addr[AW-1 -: SEL_BITS];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    slv_d     = slv_q;
    dec_err_d = dec_err_q;
    err_d     = err_q;
    gnt_d     = 1'b0;
    cnt_d     = cnt_q;
`ifndef RIB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          owner_d   = win;
          addr_d    = cand_addr[AW-SEL_BITS-1:0];
          we_d      = bus.m_we_i[win];
          wdata_d   = bus.m_data_i[int'(win)*DW +: DW];
          slv_d     = SW'(cand_sel);
          dec_err_d = (int'(cand_sel) >= NUM_S);
          gnt_d     = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // A decode error spends its ACCESS cycle without touching any slave.
        if (dec_err_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (bus.s_ack_i[slv_q]) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : bus.s_data_i[int'(slv_q)*DW +: DW];
          state_d = RESP;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
`ifndef RIB_FIXED_PRIO_EN
        last_d  = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      slv_q     <= '0;
      dec_err_q <= 1'b0;
      err_q     <= 1'b0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
`ifndef RIB_FIXED_PRIO_EN
      last_q    <= MW'(NUM_M - 1);
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      slv_q     <= slv_d;
      dec_err_q <= dec_err_d;
      err_q     <= err_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
`ifndef RIB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin
    bus.m_gnt_o    = '0;
    bus.m_rvalid_o = '0;
    bus.m_data_o   = '0;
    bus.m_err_o    = '0;
    bus.s_req_o    = '0;
    bus.s_we_o     = '0;
    bus.s_addr_o   = '0;
    bus.s_data_o   = '0;
    bus.m_gnt_o[owner_q] = gnt_q;
    if (state_q == RESP) begin
      bus.m_rvalid_o[owner_q]                = 1'b1;
      bus.m_data_o[int'(owner_q)*DW +: DW]   = rdata_q;
      bus.m_err_o[owner_q]                   = err_q;
    end
    if (state_q == ACCESS && !dec_err_q) begin
      bus.s_req_o[slv_q]                     = 1'b1;
      bus.s_we_o[slv_q]                      = we_q;
      bus.s_addr_o[int'(slv_q)*AW +: AW]     = {{SEL_BITS{1'b0}}, addr_q};
      bus.s_data_o[int'(slv_q)*DW +: DW]     = wdata_q;
    end
  end

  assign hold_flag_o = (|(bus.m_req_i & HMASK)) | ((state_q != IDLE) & HMASK[owner_q]);
endmodule
